// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side inputs and ID/EX outputs of the decode stage
interface decode_stage_if;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        flush;
  logic        stall_in;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm_out;
  logic [2:0]  funct3_out;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        a_sel_pc;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        illegal;
  modport master (
    output pc_in, instruction_in, flush, stall_in,
    input  stall_out, valid_out, pc_out, rs1_addr, rs2_addr, rd_addr, imm_out, funct3_out,
           alu_op, alu_src_imm, a_sel_pc, reg_write, mem_read, mem_write, branch, jump, illegal
  );
  modport slave (
    input  pc_in, instruction_in, flush, stall_in,
    output stall_out, valid_out, pc_out, rs1_addr, rs2_addr, rd_addr, imm_out, funct3_out,
           alu_op, alu_src_imm, a_sel_pc, reg_write, mem_read, mem_write, branch, jump, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with ID/EX register, load-use stall and one-entry replay buffer
module decode_stage #(
  parameter bit HAZARD_DETECT  = 1'b1,
  parameter bit ZERO_IS_BUBBLE = 1'b1
) (
  input logic clk,
  input logic rst_n,
  decode_stage_if.slave bus
);
  localparam logic [0:0] RUN = 1'b0, HOLD = 1'b1;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  aop;
    logic        asi;
    logic        apc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } idex_t;
  logic [0:0]  state;
  logic [31:0] buf_pc, buf_ins, pc, ins, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_misc;
  logic        use1, use2, has_rd, hazard, bubble;
  idex_t       idex, dec, nxt;
  // In HOLD the fetch outputs are already one address ahead, so the buffer is the source
  assign pc  = state == HOLD ? buf_pc : bus.pc_in;
  assign ins = state == HOLD ? buf_ins : bus.instruction_in;
  assign f3  = ins[14:12];
  assign is_lui   = ins[6:0] == 7'b0110111;
  assign is_auipc = ins[6:0] == 7'b0010111;
  assign is_jal   = ins[6:0] == 7'b1101111;
  assign is_jalr  = ins[6:0] == 7'b1100111;
  assign is_br    = ins[6:0] == 7'b1100011;
  assign is_ld    = ins[6:0] == 7'b0000011;
  assign is_st    = ins[6:0] == 7'b0100011;
  assign is_opi   = ins[6:0] == 7'b0010011;
  assign is_op    = ins[6:0] == 7'b0110011;
  assign is_misc  = ins[6:0] == 7'b0001111 || ins[6:0] == 7'b1110011;
  assign use1   = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
  assign use2   = is_br | is_st | is_op;
  assign has_rd = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op;
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'd0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.pc    = pc;
    dec.rs1   = use1 ? ins[19:15] : 5'd0;
    dec.rs2   = use2 ? ins[24:20] : 5'd0;
    dec.rd    = has_rd ? ins[11:7] : 5'd0;
    dec.imm   = (is_lui | is_auipc) ? imm_u : is_jal ? imm_j : is_br ? imm_b : is_st ? imm_s :
                (is_jalr | is_ld | is_opi) ? imm_i : 32'd0;
    dec.f3    = f3;
    dec.aop   = is_op ? {ins[30], f3} : is_opi ? {ins[30] & (f3 == 3'b101), f3} : 4'd0;
    dec.asi   = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_st | is_opi;
    dec.apc   = is_auipc | is_jal | is_jalr;
    dec.rw    = dec.rd != 5'd0;
    dec.mr    = is_ld;
    dec.mw    = is_st;
    dec.br    = is_br;
    dec.jp    = is_jal | is_jalr;
    dec.ill   = ~(has_rd | is_br | is_st | is_misc);
  end
  // Unused source fields decode to x0, which never matches a nonzero load destination
  assign hazard = HAZARD_DETECT && idex.valid && idex.mr && idex.rd != 5'd0 &&
                  (dec.rs1 == idex.rd || dec.rs2 == idex.rd);
  assign bubble = (ZERO_IS_BUBBLE && ins == 32'd0) || bus.flush || hazard;
  assign nxt    = bubble ? '0 : dec;
  assign bus.stall_out = (hazard || bus.stall_in) && !bus.flush && rst_n;
  assign {bus.valid_out, bus.pc_out, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.imm_out,
          bus.funct3_out, bus.alu_op, bus.alu_src_imm, bus.a_sel_pc, bus.reg_write,
          bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.illegal} = idex;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      buf_pc  <= '0;
      buf_ins <= '0;
      idex    <= '0;
    end else begin
      if (!(bus.stall_out && bus.stall_in)) idex <= nxt;
      state   <= bus.stall_out ? HOLD : RUN;
      buf_pc  <= bus.stall_out ? pc : 32'd0;
      buf_ins <= bus.stall_out ? ins : 32'd0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus checked against a behavioural decode model
module tb_decode_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  aop;
    logic        asi;
    logic        apc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } dec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decode_stage_if bus();
  decode_stage #(.HAZARD_DETECT(1'b1), .ZERO_IS_BUBBLE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int vecs = 0;
  int errs = 0;
  dec_t exp_r = '0;
  dec_t m_sd;
  logic m_stall;
  logic [63:0] m_src;
  logic [63:0] q[$];
  logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h03};

  function automatic dec_t mdec(input logic [31:0] pc, input logic [31:0] w);
    dec_t d;
    logic [31:0] ii, si, bi, ui, ji;
    d = '0;
    if (w == 32'd0) return d;
    ii = 32'($signed(w) >>> 20);
    si = {ii[31:5], w[11:7]};
    bi = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    ui = w & 32'hFFFF_F000;
    ji = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    d.valid = 1'b1;
    d.pc = pc;
    d.f3 = w[14:12];
    case (w[6:0])
      7'b0110111: begin d.rd = w[11:7]; d.imm = ui; d.asi = 1'b1; end
      7'b0010111: begin d.rd = w[11:7]; d.imm = ui; d.asi = 1'b1; d.apc = 1'b1; end
      7'b1101111: begin d.rd = w[11:7]; d.imm = ji; d.asi = 1'b1; d.apc = 1'b1; d.jp = 1'b1; end
      7'b1100111: begin d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = ii; d.asi = 1'b1; d.apc = 1'b1; d.jp = 1'b1; end
      7'b1100011: begin d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.imm = bi; d.br = 1'b1; end
      7'b0000011: begin d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = ii; d.asi = 1'b1; d.mr = 1'b1; end
      7'b0100011: begin d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.imm = si; d.asi = 1'b1; d.mw = 1'b1; end
      7'b0010011: begin
        d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = ii; d.asi = 1'b1;
        d.aop = {w[14:12] == 3'd5 && w[30], w[14:12]};
      end
      7'b0110011: begin d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; d.aop = {w[30], w[14:12]}; end
      7'b0001111, 7'b1110011: ;
      default: d.ill = 1'b1;
    endcase
    d.rw = d.rd != 5'd0;
    return d;
  endfunction

  function automatic logic haz(input dec_t s);
    return exp_r.valid && exp_r.mr && exp_r.rd != 5'd0 && (s.rs1 == exp_r.rd || s.rs2 == exp_r.rd);
  endfunction

  function automatic dec_t dut_val();
    return {bus.valid_out, bus.pc_out, bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.imm_out,
            bus.funct3_out, bus.alu_op, bus.alu_src_imm, bus.a_sel_pc, bus.reg_write,
            bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.illegal};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (k == 12) return 32'd0;
    w[6:0] = k == 13 ? 7'h7F : ops[k];
    return w;
  endfunction

  task automatic lit(input string n, input logic [31:0] g, input logic [31:0] e);
    vecs++;
    if (g !== e) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", n, g, e);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic fl, input logic st);
    dec_t g;
    @(negedge clk);
    bus.pc_in = pc;
    bus.instruction_in = ins;
    bus.flush = fl;
    bus.stall_in = st;
    #1;
    m_src = q.size() != 0 ? q[0] : {pc, ins};
    m_sd = mdec(m_src[63:32], m_src[31:0]);
    m_stall = (haz(m_sd) || st) && !fl;
    g = dut_val();
    vecs++;
    if (g !== exp_r || bus.stall_out !== m_stall) begin
      errs++;
      $display("FAIL cycle pc_in=%h: got %h stall=%b, expected %h stall=%b", pc, g, bus.stall_out, exp_r, m_stall);
    end
  endtask

  task automatic adv();
    if (bus.flush) begin
      exp_r = '0;
      q.delete();
    end else if (m_stall) begin
      if (q.size() == 0) q.push_back(m_src);
      if (!bus.stall_in) exp_r = '0;
    end else begin
      exp_r = m_sd;
      q.delete();
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    lit("rst valid_out", 32'(bus.valid_out), 32'd0);
    lit("rst pc_out", bus.pc_out, 32'd0);
    lit("rst stall_out", 32'(bus.stall_out), 32'd0);
    exp_r = '0;
    q.delete();
    bus.pc_in = '0;
    bus.instruction_in = '0;
    bus.flush = 1'b0;
    bus.stall_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    bus.pc_in = '0;
    bus.instruction_in = '0;
    bus.flush = 1'b0;
    bus.stall_in = 1'b0;
    do_reset();
    drive(32'h314, 32'h00500093, 0, 0); adv();
    drive(32'h318, 32'h00012283, 0, 0);
    lit("addi valid", 32'(bus.valid_out), 32'd1);
    lit("addi rd", 32'(bus.rd_addr), 32'd1);
    lit("addi imm", bus.imm_out, 32'd5);
    lit("addi src_imm", 32'(bus.alu_src_imm), 32'd1);
    lit("addi reg_write", 32'(bus.reg_write), 32'd1);
    lit("addi stall", 32'(bus.stall_out), 32'd0);
    adv();
    drive(32'h31C, 32'h00128333, 0, 0);
    lit("loaduse stall", 32'(bus.stall_out), 32'd1);
    adv();
    drive(32'h320, 32'h00A00513, 0, 0);
    lit("loaduse release", 32'(bus.stall_out), 32'd0);
    lit("loaduse bubble", 32'(bus.valid_out), 32'd0);
    adv();
    drive(32'h320, 32'h00A00513, 0, 0);
    lit("replay pc", bus.pc_out, 32'h31C);
    lit("replay rs1", 32'(bus.rs1_addr), 32'd5);
    adv();
    drive(32'h324, 32'h00012283, 0, 0); adv();
    drive(32'h328, 32'h00100333, 0, 0);
    lit("lw then x0 src", 32'(bus.stall_out), 32'd0);
    adv();
    drive(32'h32C, 32'h00012003, 0, 0); adv();
    drive(32'h330, 32'h00128333, 0, 0);
    lit("lw x0 no stall", 32'(bus.stall_out), 32'd0);
    adv();
    drive(32'h334, 32'hFE208CE3, 0, 0); adv();
    drive(32'h338, 32'h001000EF, 0, 0);
    lit("beq branch", 32'(bus.branch), 32'd1);
    lit("beq imm", bus.imm_out, 32'hFFFFFFF8);
    lit("beq rd", 32'(bus.rd_addr), 32'd0);
    lit("beq reg_write", 32'(bus.reg_write), 32'd0);
    adv();
    drive(32'h33C, 32'h00000013, 0, 0);
    lit("jal imm", bus.imm_out, 32'h800);
    lit("jal jump", 32'(bus.jump), 32'd1);
    lit("jal a_sel_pc", 32'(bus.a_sel_pc), 32'd1);
    adv();
    drive(32'h400, 32'h00100093, 0, 0); adv();
    drive(32'h404, 32'h00200113, 0, 1);
    lit("stall_in stall", 32'(bus.stall_out), 32'd1);
    adv();
    drive(32'h408, 32'h00300193, 1, 1);
    lit("frozen pc", bus.pc_out, 32'h400);
    lit("flush stall", 32'(bus.stall_out), 32'd0);
    adv();
    drive(32'h40C, 32'h00400213, 0, 1);
    lit("flush bubble", 32'(bus.valid_out), 32'd0);
    adv();
    drive(32'h40C, 32'h00400213, 0, 0); adv();
    drive(32'h410, 32'h00000013, 0, 0);
    lit("post flush buffer pc", bus.pc_out, 32'h40C);
    adv();
    drive(32'h480, 32'h00000000, 0, 0); adv();
    drive(32'h484, 32'h0000007F, 0, 0);
    lit("zero valid", 32'(bus.valid_out), 32'd0);
    lit("zero illegal", 32'(bus.illegal), 32'd0);
    adv();
    drive(32'h488, 32'h00000013, 0, 0);
    lit("illegal valid", 32'(bus.valid_out), 32'd1);
    lit("illegal flag", 32'(bus.illegal), 32'd1);
    adv();
    drive(32'h600, 32'h00100093, 0, 0); adv();
    drive(32'h604, 32'h00200113, 0, 1); adv();
    do_reset();
    drive(32'h700, 32'h00300193, 0, 0); adv();
    drive(32'h704, 32'h00000013, 0, 0);
    lit("run after reset pc", bus.pc_out, 32'h700);
    adv();
    pc = 32'h1000;
    repeat (3000) begin
      drive(pc, rand_ins(), $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
      adv();
      pc += 4;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
